// File: rtl/i2c_sync_slave_rx_if.sv
// I2C bus lines plus the FIFO-side strobes of the synchronous slave receiver.
// Member names match the original module ports.
interface i2c_sync_slave_rx_if;
   logic       SCL;
   logic       SDA;
   logic       sda_oe;
   logic       i_fifo_full;
   logic [7:0] o_data;
   logic       o_valid;
   logic       o_drop;
   logic       o_busy;

   modport slave (
      input  SCL, SDA, i_fifo_full,
      output sda_oe, o_data, o_valid, o_drop, o_busy
   );

   modport master (
      output SCL, SDA, i_fifo_full,
      input  sda_oe, o_data, o_valid, o_drop, o_busy
   );
endinterface

// File: rtl/i2c_sync_slave_rx.sv
// Oversampling I2C write-only slave receiver; strobes each accepted byte into a FIFO
// and NACKs bytes that arrive while the FIFO is full.
module i2c_sync_slave_rx #(
   parameter logic [6:0]  SLAVE_ADDR = 7'h42,
   parameter int unsigned FILTER_LEN = 3
) (
   input  logic              clk,
   input  logic              reset,
   i2c_sync_slave_rx_if.slave bus
);

   localparam logic [2:0] FLEN_M1 = 3'(FILTER_LEN - 1);

   typedef enum logic [2:0] {
      IDLE,
      ADDR,
      ADDR_ACK,
      DATA,
      DATA_ACK,
      IGNORE
   } state_t;

   state_t     state;
   logic       scl_s1, scl_s2, sda_s1, sda_s2;
   logic       scl_f, sda_f, scl_d, sda_d;
   logic [2:0] scl_cnt, sda_cnt;
   logic [2:0] bit_cnt;
   logic [6:0] shift;
   logic       ack_arm;
   logic       ack_half;

   logic       scl_rise, scl_fall, start_det, stop_det;
   logic [7:0] next_byte;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         scl_s1 <= 1'b1;
         scl_s2 <= 1'b1;
         sda_s1 <= 1'b1;
         sda_s2 <= 1'b1;
      end else begin
         scl_s1 <= bus.SCL;
         scl_s2 <= scl_s1;
         sda_s1 <= bus.SDA;
         sda_s2 <= sda_s1;
      end
   end

   // A filtered level moves only after FILTER_LEN consecutive disagreeing samples.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         scl_f   <= 1'b1;
         scl_cnt <= '0;
      end else if (scl_s2 != scl_f) begin
         if (scl_cnt == FLEN_M1) begin
            scl_f   <= scl_s2;
            scl_cnt <= '0;
         end else begin
            scl_cnt <= scl_cnt + 3'd1;
         end
      end else begin
         scl_cnt <= '0;
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         sda_f   <= 1'b1;
         sda_cnt <= '0;
      end else if (sda_s2 != sda_f) begin
         if (sda_cnt == FLEN_M1) begin
            sda_f   <= sda_s2;
            sda_cnt <= '0;
         end else begin
            sda_cnt <= sda_cnt + 3'd1;
         end
      end else begin
         sda_cnt <= '0;
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         scl_d <= 1'b1;
         sda_d <= 1'b1;
      end else begin
         scl_d <= scl_f;
         sda_d <= sda_f;
      end
   end

   always_comb begin
      scl_rise  = scl_f & ~scl_d;
      scl_fall  = ~scl_f & scl_d;
      start_det = scl_f & scl_d & sda_d & ~sda_f;
      stop_det  = scl_f & scl_d & ~sda_d & sda_f;
      next_byte = {shift, sda_f};
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state       <= IDLE;
         bit_cnt     <= '0;
         shift       <= '0;
         ack_arm     <= 1'b0;
         ack_half    <= 1'b0;
         bus.sda_oe  <= 1'b0;
         bus.o_data  <= '0;
         bus.o_valid <= 1'b0;
         bus.o_drop  <= 1'b0;
         bus.o_busy  <= 1'b0;
      end else begin
         bus.o_valid <= 1'b0;
         bus.o_drop  <= 1'b0;
         if (stop_det) begin
            state      <= IDLE;
            bit_cnt    <= '0;
            ack_half   <= 1'b0;
            bus.sda_oe <= 1'b0;
            bus.o_busy <= 1'b0;
         end else if (start_det) begin
            state      <= ADDR;
            bit_cnt    <= '0;
            ack_half   <= 1'b0;
            bus.sda_oe <= 1'b0;
         end else begin
            case (state)
               ADDR: begin
                  if (scl_rise) begin
                     shift   <= next_byte[6:0];
                     bit_cnt <= bit_cnt + 3'd1;
                     if (bit_cnt == 3'd7) begin
                        if (next_byte[7:1] == SLAVE_ADDR && !next_byte[0]) begin
                           state      <= ADDR_ACK;
                           ack_arm    <= 1'b1;
                           bus.o_busy <= 1'b1;
                        end else begin
                           state      <= IGNORE;
                           bus.o_busy <= 1'b0;
                        end
                     end
                  end
               end
               // First fall after the 8th bit starts the ACK slot, the second ends it.
               ADDR_ACK, DATA_ACK: begin
                  if (scl_fall) begin
                     if (!ack_half) begin
                        ack_half   <= 1'b1;
                        bus.sda_oe <= ack_arm;
                     end else begin
                        ack_half   <= 1'b0;
                        bus.sda_oe <= 1'b0;
                        bit_cnt    <= '0;
                        state      <= DATA;
                     end
                  end
               end
               DATA: begin
                  if (scl_rise) begin
                     shift   <= next_byte[6:0];
                     bit_cnt <= bit_cnt + 3'd1;
                     if (bit_cnt == 3'd7) begin
                        state <= DATA_ACK;
                        if (!bus.i_fifo_full) begin
                           bus.o_data  <= next_byte;
                           bus.o_valid <= 1'b1;
                           ack_arm     <= 1'b1;
                        end else begin
                           bus.o_drop <= 1'b1;
                           ack_arm    <= 1'b0;
                        end
                     end
                  end
               end
               default: ;
            endcase
         end
      end
   end

endmodule

// File: tb/tb_i2c_sync_slave_rx.sv
// Directed bench for i2c_sync_slave_rx: bit-banged I2C master with an open-drain
// SDA model and a strobe monitor.
`timescale 1ns/1ps
module tb_i2c_sync_slave_rx;

   localparam int FL = 3;
   localparam int LAT = FL + 3;

   logic clk = 1'b0;
   logic reset;
   logic m_sda;

   always #50 clk = ~clk;

   i2c_sync_slave_rx_if bus();
   assign bus.SDA = m_sda & ~bus.sda_oe;

   i2c_sync_slave_rx #(
      .SLAVE_ADDR(7'h42),
      .FILTER_LEN(FL)
   ) dut (
      .clk  (clk),
      .reset(reset),
      .bus  (bus)
   );

   int vectors = 0;
   int miscompares = 0;
   int cyc = 0;
   int n_valid = 0, n_drop = 0, n_both = 0, n_oe = 0;
   int valid_cyc = 0, oe_cyc = 0;
   logic oe_prev = 1'b0;
   int rise_cyc = 0, fall_cyc = 0, byte_rise_cyc = 0, byte_fall_cyc = 0;

   always @(posedge clk) cyc <= cyc + 1;

   always @(negedge clk) begin
      if (bus.o_valid) begin
         n_valid   <= n_valid + 1;
         valid_cyc <= cyc;
      end
      if (bus.o_drop) n_drop <= n_drop + 1;
      if (bus.o_valid && bus.o_drop) n_both <= n_both + 1;
      if (bus.sda_oe && !oe_prev) begin
         n_oe   <= n_oe + 1;
         oe_cyc <= cyc;
      end
      oe_prev <= bus.sda_oe;
   end

   initial begin
      #10_000_000;
      $display("FAIL watchdog: time limit reached before summary");
      $fatal(1);
   end

   task automatic wclk(input int n);
      repeat (n) @(negedge clk);
   endtask

   // gkind: 0 none, 1 = 2-clk low pulse on SCL, 2 = 2-clk inverted pulse on SDA (both while SCL high)
   task automatic bit_out(input logic b, input int gkind, output logic sampled);
      wclk(25);
      m_sda = b;
      wclk(25);
      bus.SCL = 1'b1;
      rise_cyc = cyc;
      wclk(20);
      if (gkind == 1) begin
         bus.SCL = 1'b0;
         wclk(2);
         bus.SCL = 1'b1;
      end else if (gkind == 2) begin
         m_sda = ~b;
         wclk(2);
         m_sda = b;
      end else begin
         wclk(2);
      end
      wclk(3);
      sampled = bus.SDA;
      wclk(25);
      bus.SCL = 1'b0;
      fall_cyc = cyc;
   endtask

   task automatic send_byte(input logic [7:0] d, input int gbit, input int gkind, output logic ack);
      logic s;
      for (int i = 7; i >= 0; i--) begin
         bit_out(d[i], (i == gbit) ? gkind : 0, s);
      end
      byte_rise_cyc = rise_cyc;
      byte_fall_cyc = fall_cyc;
      bit_out(1'b1, 0, s);
      ack = ~s;
   endtask

   task automatic start_cond();
      m_sda = 1'b1;
      bus.SCL = 1'b1;
      wclk(25);
      m_sda = 1'b0;
      wclk(25);
      bus.SCL = 1'b0;
   endtask

   task automatic rep_start();
      wclk(25);
      m_sda = 1'b1;
      wclk(25);
      bus.SCL = 1'b1;
      wclk(25);
      m_sda = 1'b0;
      wclk(25);
      bus.SCL = 1'b0;
   endtask

   task automatic stop_cond();
      wclk(25);
      m_sda = 1'b0;
      wclk(25);
      bus.SCL = 1'b1;
      wclk(25);
      m_sda = 1'b1;
      wclk(50);
   endtask

   task automatic test_reset();
      vectors++;
      if (bus.sda_oe !== 1'b0) begin miscompares++; $display("FAIL reset_sda_oe: got %b want 0", bus.sda_oe); end
      vectors++;
      if (bus.o_valid !== 1'b0) begin miscompares++; $display("FAIL reset_o_valid: got %b want 0", bus.o_valid); end
      vectors++;
      if (bus.o_drop !== 1'b0) begin miscompares++; $display("FAIL reset_o_drop: got %b want 0", bus.o_drop); end
      vectors++;
      if (bus.o_busy !== 1'b0) begin miscompares++; $display("FAIL reset_o_busy: got %b want 0", bus.o_busy); end
      vectors++;
      if (bus.o_data !== 8'h00) begin miscompares++; $display("FAIL reset_o_data: got %h want 00", bus.o_data); end
   endtask

   task automatic test_basic_write();
      logic ack;
      int v0, d0;
      v0 = n_valid;
      d0 = n_drop;
      start_cond();
      send_byte(8'h84, -1, 0, ack);
      vectors++;
      if (ack !== 1'b1) begin miscompares++; $display("FAIL basic_addr_ack: got %b want 1", ack); end
      send_byte(8'hA5, -1, 0, ack);
      vectors++;
      if (ack !== 1'b1) begin miscompares++; $display("FAIL basic_data_ack: got %b want 1", ack); end
      vectors++;
      if (valid_cyc - byte_rise_cyc !== LAT) begin miscompares++; $display("FAIL basic_valid_latency: got %0d want %0d", valid_cyc - byte_rise_cyc, LAT); end
      vectors++;
      if (oe_cyc - byte_fall_cyc !== LAT) begin miscompares++; $display("FAIL basic_oe_latency: got %0d want %0d", oe_cyc - byte_fall_cyc, LAT); end
      vectors++;
      if (bus.o_busy !== 1'b1) begin miscompares++; $display("FAIL basic_busy_before_stop: got %b want 1", bus.o_busy); end
      stop_cond();
      vectors++;
      if (bus.o_busy !== 1'b0) begin miscompares++; $display("FAIL basic_busy_after_stop: got %b want 0", bus.o_busy); end
      vectors++;
      if (n_valid - v0 !== 1) begin miscompares++; $display("FAIL basic_valid_count: got %0d want 1", n_valid - v0); end
      vectors++;
      if (n_drop - d0 !== 0) begin miscompares++; $display("FAIL basic_drop_count: got %0d want 0", n_drop - d0); end
      vectors++;
      if (bus.o_data !== 8'hA5) begin miscompares++; $display("FAIL basic_o_data: got %h want a5", bus.o_data); end
   endtask

   task automatic test_wrong_addr();
      logic ack_a, ack_d;
      int v0, o0;
      v0 = n_valid;
      o0 = n_oe;
      start_cond();
      send_byte(8'hA0, -1, 0, ack_a);
      send_byte(8'h11, -1, 0, ack_d);
      vectors++;
      if (bus.o_busy !== 1'b0) begin miscompares++; $display("FAIL wrong_addr_busy: got %b want 0", bus.o_busy); end
      stop_cond();
      vectors++;
      if ({ack_a, ack_d} !== 2'b00) begin miscompares++; $display("FAIL wrong_addr_acks: got %b want 00", {ack_a, ack_d}); end
      vectors++;
      if (n_oe - o0 !== 0) begin miscompares++; $display("FAIL wrong_addr_oe: got %0d want 0", n_oe - o0); end
      vectors++;
      if (n_valid - v0 !== 0) begin miscompares++; $display("FAIL wrong_addr_valid: got %0d want 0", n_valid - v0); end
   endtask

   task automatic test_read_bit();
      logic ack;
      int v0, d0, o0;
      v0 = n_valid;
      d0 = n_drop;
      o0 = n_oe;
      start_cond();
      send_byte(8'h85, -1, 0, ack);
      vectors++;
      if (bus.o_busy !== 1'b0) begin miscompares++; $display("FAIL read_bit_busy: got %b want 0", bus.o_busy); end
      stop_cond();
      vectors++;
      if (ack !== 1'b0) begin miscompares++; $display("FAIL read_bit_ack: got %b want 0", ack); end
      vectors++;
      if ((n_valid - v0) + (n_drop - d0) + (n_oe - o0) !== 0) begin
         miscompares++;
         $display("FAIL read_bit_activity: got valid %0d drop %0d oe %0d want 0 0 0", n_valid - v0, n_drop - d0, n_oe - o0);
      end
   endtask

   task automatic test_back_to_back();
      logic a0, a1, a2, a3;
      int v0, d0;
      v0 = n_valid;
      d0 = n_drop;
      start_cond();
      send_byte(8'h84, -1, 0, a0);
      send_byte(8'h01, -1, 0, a1);
      bus.i_fifo_full = 1'b1;
      send_byte(8'h02, -1, 0, a2);
      bus.i_fifo_full = 1'b0;
      vectors++;
      if (bus.o_data !== 8'h01) begin miscompares++; $display("FAIL full_data_held: got %h want 01", bus.o_data); end
      send_byte(8'h03, -1, 0, a3);
      stop_cond();
      vectors++;
      if ({a0, a1, a2, a3} !== 4'b1101) begin miscompares++; $display("FAIL full_acks: got %b want 1101", {a0, a1, a2, a3}); end
      vectors++;
      if (n_valid - v0 !== 2) begin miscompares++; $display("FAIL full_valid_count: got %0d want 2", n_valid - v0); end
      vectors++;
      if (n_drop - d0 !== 1) begin miscompares++; $display("FAIL full_drop_count: got %0d want 1", n_drop - d0); end
      vectors++;
      if (n_both !== 0) begin miscompares++; $display("FAIL full_valid_and_drop: got %0d want 0", n_both); end
      vectors++;
      if (bus.o_data !== 8'h03) begin miscompares++; $display("FAIL full_final_data: got %h want 03", bus.o_data); end
   endtask

   task automatic test_glitch();
      logic a0, a1;
      int v0;
      v0 = n_valid;
      start_cond();
      send_byte(8'h84, -1, 0, a0);
      // 0x5A: SCL glitch on bit 3 (value 1), SDA glitch on bit 6 (value 1)
      send_byte(8'h5A, 3, 1, a1);
      stop_cond();
      start_cond();
      send_byte(8'h84, -1, 0, a0);
      send_byte(8'h5A, 6, 2, a1);
      stop_cond();
      vectors++;
      if ({a0, a1} !== 2'b11) begin miscompares++; $display("FAIL glitch_acks: got %b want 11", {a0, a1}); end
      vectors++;
      if (n_valid - v0 !== 2) begin miscompares++; $display("FAIL glitch_valid_count: got %0d want 2", n_valid - v0); end
      vectors++;
      if (bus.o_data !== 8'h5A) begin miscompares++; $display("FAIL glitch_data: got %h want 5a", bus.o_data); end
   endtask

   task automatic test_repeated_start();
      logic a0, a1, s;
      int v0;
      logic [3:0] part;
      v0 = n_valid;
      part = 4'b1011;
      start_cond();
      send_byte(8'h84, -1, 0, a0);
      for (int i = 3; i >= 0; i--) bit_out(part[i], 0, s);
      rep_start();
      send_byte(8'h84, -1, 0, a0);
      send_byte(8'h77, -1, 0, a1);
      stop_cond();
      vectors++;
      if ({a0, a1} !== 2'b11) begin miscompares++; $display("FAIL rstart_acks: got %b want 11", {a0, a1}); end
      vectors++;
      if (n_valid - v0 !== 1) begin miscompares++; $display("FAIL rstart_valid_count: got %0d want 1", n_valid - v0); end
      vectors++;
      if (bus.o_data !== 8'h77) begin miscompares++; $display("FAIL rstart_data: got %h want 77", bus.o_data); end
   endtask

   task automatic test_reset_mid_ack();
      logic a0, s;
      logic [7:0] d;
      int v0;
      d = 8'h3C;
      start_cond();
      send_byte(8'h84, -1, 0, a0);
      for (int i = 7; i >= 0; i--) bit_out(d[i], 0, s);
      wclk(15);
      vectors++;
      if (bus.sda_oe !== 1'b1) begin miscompares++; $display("FAIL midack_oe_before: got %b want 1", bus.sda_oe); end
      reset = 1'b0;
      #1;
      vectors++;
      if (bus.sda_oe !== 1'b0) begin miscompares++; $display("FAIL midack_oe_async: got %b want 0", bus.sda_oe); end
      vectors++;
      if ({bus.o_busy, bus.o_data} !== 9'h000) begin miscompares++; $display("FAIL midack_busy_data: got %h want 000", {bus.o_busy, bus.o_data}); end
      bus.SCL = 1'b1;
      m_sda = 1'b1;
      wclk(10);
      reset = 1'b1;
      wclk(20);
      v0 = n_valid;
      start_cond();
      send_byte(8'h84, -1, 0, a0);
      send_byte(8'h99, -1, 0, s);
      stop_cond();
      vectors++;
      if ({a0, s} !== 2'b11) begin miscompares++; $display("FAIL midack_after_acks: got %b want 11", {a0, s}); end
      vectors++;
      if (n_valid - v0 !== 1) begin miscompares++; $display("FAIL midack_after_valid: got %0d want 1", n_valid - v0); end
      vectors++;
      if (bus.o_data !== 8'h99) begin miscompares++; $display("FAIL midack_after_data: got %h want 99", bus.o_data); end
   endtask

   initial begin
      reset = 1'b0;
      bus.SCL = 1'b1;
      bus.i_fifo_full = 1'b0;
      m_sda = 1'b1;
      wclk(5);
      test_reset();
      reset = 1'b1;
      wclk(20);
      test_basic_write();
      test_wrong_addr();
      test_read_bit();
      test_back_to_back();
      test_glitch();
      test_repeated_start();
      test_reset_mid_ack();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
